// File: rtl/sha256_w_sched.sv
// rtl/sha256_w_sched.sv - SHA-256 message-schedule generator with sigma helpers
// Define SHA256_W_SCHED_B2B_EN to chain blocks with no idle cycle between them.

module sha256_s0 (
   input  logic [31:0] x_i,
   output logic [31:0] y_o
);
   assign y_o = {x_i[6:0], x_i[31:7]} ^ {x_i[17:0], x_i[31:18]} ^ {3'b000, x_i[31:3]};
endmodule

module sha256_s1 (
   input  logic [31:0] x_i,
   output logic [31:0] y_o
);
   assign y_o = {x_i[16:0], x_i[31:17]} ^ {x_i[18:0], x_i[31:19]} ^ {10'd0, x_i[31:10]};
endmodule

module sha256_w_sched #(
   parameter int NUM_ROUNDS = 64   // 16..64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         block_valid,
   output logic         block_ready,
   input  logic [511:0] block,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w,
   output logic [5:0]   w_idx,
   output logic         w_last
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

   state_t      state_q;
   logic [31:0] win_q [16];
   logic [5:0]  t_q;
   logic        w_last_q;
   logic [31:0] s0_w;
   logic [31:0] s1_w;
   logic [31:0] w16_d;
   logic        load;

   sha256_s0 u_s0 (.x_i(win_q[1]),  .y_o(s0_w));
   sha256_s1 u_s1 (.x_i(win_q[14]), .y_o(s1_w));

   // W[t+16] from the current window; becomes the new tail on every shift.
   assign w16_d = s1_w + win_q[9] + s0_w + win_q[0];

`ifdef SHA256_W_SCHED_B2B_EN
   assign block_ready = (state_q == IDLE) | (w_last_q & w_ready);
`else
   assign block_ready = (state_q == IDLE);
`endif

   assign load    = block_valid & block_ready;
   assign w_valid = (state_q == RUN);
   assign w       = win_q[0];
   assign w_idx   = t_q;
   assign w_last  = w_last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         t_q      <= 6'd0;
         w_last_q <= 1'b0;
         for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
      end else if (load) begin
         state_q  <= RUN;
         t_q      <= 6'd0;
         w_last_q <= 1'b0;
         for (int i = 0; i < 16; i++) win_q[i] <= block[511 - 32*i -: 32];
      end else if (state_q == RUN && w_ready) begin
         for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
         win_q[15] <= w16_d;
         if (w_last_q) begin
            state_q  <= IDLE;
            t_q      <= 6'd0;
            w_last_q <= 1'b0;
         end else begin
            t_q      <= t_q + 6'd1;
            w_last_q <= (t_q + 6'd1 == LAST_IDX);
         end
      end
   end
endmodule

// File: tb/tb_sha256_w_sched.sv
// tb/tb_sha256_w_sched.sv - directed self-checking bench for sha256_w_sched
module tb_sha256_w_sched;

`ifdef SHA256_W_SCHED_B2B_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         block_valid, w_ready;
   logic [511:0] blk;
   logic         block_ready, w_valid, w_last;
   logic [31:0]  w;
   logic [5:0]   w_idx;

   logic         block_valid16, w_ready16;
   logic [511:0] blk16;
   logic         block_ready16, w_valid16, w_last16;
   logic [31:0]  w16;
   logic [5:0]   w_idx16;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [31:0] ref_w [64];

   always #5 clk = ~clk;

   sha256_w_sched dut (
      .clk(clk), .rst(rst),
      .block_valid(block_valid), .block_ready(block_ready), .block(blk),
      .w_valid(w_valid), .w_ready(w_ready), .w(w), .w_idx(w_idx), .w_last(w_last)
   );

   sha256_w_sched #(.NUM_ROUNDS(16)) dut16 (
      .clk(clk), .rst(rst),
      .block_valid(block_valid16), .block_ready(block_ready16), .block(blk16),
      .w_valid(w_valid16), .w_ready(w_ready16), .w(w16), .w_idx(w_idx16), .w_last(w_last16)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // FIPS 180-4 schedule expansion
   task automatic gen_sched(input logic [511:0] b);
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) ref_w[t] = b[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
         s1 = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
         ref_w[t] = ref_w[t-16] + s0 + ref_w[t-7] + s1;
      end
   endtask

   function automatic logic [511:0] patt(input logic [31:0] seed);
      logic [511:0] b;
      b = '0;
      for (int i = 0; i < 16; i++)
         b[511 - 32*i -: 32] = (seed * 32'h9E3779B9 + 32'(i) * 32'h01000193) ^ {seed[7:0], 24'h5A5A5A};
      return b;
   endfunction

   // Presents b, waits for the handshake, returns at the negedge where W[0] should show.
   task automatic load(input logic [511:0] b);
      int n;
      n = 0;
      @(negedge clk);
      blk = b;
      block_valid = 1'b1;
      while (!block_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!block_ready) begin
         vec_cnt++; err_cnt++;
         $display("FAIL load_timeout: block_ready=%b after %0d cycles, expected 1", block_ready, n);
      end
      @(negedge clk);
      block_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      block_valid = 1'b0; w_ready = 1'b0; blk = '0;
      block_valid16 = 1'b0; w_ready16 = 1'b0; blk16 = '0;
      repeat (2) @(negedge clk);
      vec_cnt++; if (block_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_block_ready: got %b expected 1", block_ready); end
      vec_cnt++; if (w_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_w_valid: got %b expected 0", w_valid); end
      vec_cnt++; if (w !== 32'd0) begin err_cnt++; $display("FAIL reset_w: got %08h expected 00000000", w); end
      vec_cnt++; if (w_idx !== 6'd0) begin err_cnt++; $display("FAIL reset_w_idx: got %0d expected 0", w_idx); end
      vec_cnt++; if (w_last !== 1'b0) begin err_cnt++; $display("FAIL reset_w_last: got %b expected 0", w_last); end
      vec_cnt++; if (w_valid16 !== 1'b0 || block_ready16 !== 1'b1) begin
         err_cnt++; $display("FAIL reset_r16: got valid=%b ready=%b expected 0/1", w_valid16, block_ready16);
      end
      rst = 1'b0;
   endtask

   task automatic test_abc();
      logic [511:0] b;
      b = {32'h61626380, 448'd0, 32'h00000018};
      gen_sched(b);
      w_ready = 1'b1;
      load(b);
      for (int t = 0; t < 64; t++) begin
         if (t > 0) @(negedge clk);
         vec_cnt++;
         if (w_valid !== 1'b1 || w !== ref_w[t] || w_idx !== 6'(t) || w_last !== (t == 63)) begin
            err_cnt++;
            $display("FAIL abc_word t=%0d: got valid=%b w=%08h idx=%0d last=%b expected w=%08h last=%b",
                     t, w_valid, w, w_idx, w_last, ref_w[t], (t == 63));
         end
         if (t == 16) begin
            vec_cnt++; if (w !== 32'h61626380) begin err_cnt++; $display("FAIL abc_w16: got %08h expected 61626380", w); end
         end
         if (t == 17) begin
            vec_cnt++; if (w !== 32'h000F0000) begin err_cnt++; $display("FAIL abc_w17: got %08h expected 000f0000", w); end
         end
      end
      @(negedge clk);
      vec_cnt++; if (w_valid !== 1'b0) begin err_cnt++; $display("FAIL abc_end_valid: got %b expected 0", w_valid); end
   endtask

   task automatic test_sigma0();
      logic [511:0] b;
      b = {32'd0, 32'h00000008, 448'd0};
      gen_sched(b);
      w_ready = 1'b1;
      load(b);
      for (int t = 0; t < 64; t++) begin
         if (t > 0) @(negedge clk);
         vec_cnt++;
         if (w_valid !== 1'b1 || w !== ref_w[t] || w_idx !== 6'(t)) begin
            err_cnt++;
            $display("FAIL sigma0_word t=%0d: got w=%08h idx=%0d expected w=%08h", t, w, w_idx, ref_w[t]);
         end
         if (t == 16) begin
            vec_cnt++; if (w !== 32'h10020001) begin err_cnt++; $display("FAIL sigma0_w16: got %08h expected 10020001", w); end
         end
         if (t == 17) begin
            vec_cnt++; if (w !== 32'h00000008) begin err_cnt++; $display("FAIL sigma0_w17: got %08h expected 00000008", w); end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [511:0] b;
      int t, stalls, cyc;
      b = patt(32'd1);
      gen_sched(b);
      w_ready = 1'b1;
      load(b);
      t = 0; stalls = 0; cyc = 0;
      while (t < 64 && cyc < 100) begin
         vec_cnt++;
         if (w_valid !== 1'b1 || w !== ref_w[t] || w_idx !== 6'(t) || w_last !== (t == 63)) begin
            err_cnt++;
            $display("FAIL bp_word t=%0d stall=%0d: got valid=%b w=%08h idx=%0d last=%b expected w=%08h",
                     t, stalls, w_valid, w, w_idx, w_last, ref_w[t]);
         end
         if (t == 20 && stalls < 5) begin
            w_ready = 1'b0;
            stalls++;
         end else begin
            w_ready = 1'b1;
            t++;
         end
         @(negedge clk);
         cyc++;
      end
      vec_cnt++; if (t != 64) begin err_cnt++; $display("FAIL bp_timeout: reached t=%0d expected 64", t); end
      vec_cnt++; if (w_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_end_valid: got %b expected 0", w_valid); end
   endtask

   task automatic test_reset_mid();
      logic [511:0] b;
      b = patt(32'd2);
      gen_sched(b);
      w_ready = 1'b1;
      load(b);
      for (int t = 0; t < 30; t++) @(negedge clk);
      vec_cnt++; if (w_idx !== 6'd30 || w !== ref_w[30]) begin
         err_cnt++; $display("FAIL rstmid_pre: got idx=%0d w=%08h expected idx=30 w=%08h", w_idx, w, ref_w[30]);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vec_cnt++;
      if (w_valid !== 1'b0 || block_ready !== 1'b1 || w !== 32'd0 || w_idx !== 6'd0) begin
         err_cnt++;
         $display("FAIL rstmid_post: got valid=%b ready=%b w=%08h idx=%0d expected 0/1/00000000/0",
                  w_valid, block_ready, w, w_idx);
      end
      b = patt(32'd3);
      gen_sched(b);
      load(b);
      for (int t = 0; t < 64; t++) begin
         if (t > 0) @(negedge clk);
         vec_cnt++;
         if (w_valid !== 1'b1 || w !== ref_w[t] || w_idx !== 6'(t)) begin
            err_cnt++;
            $display("FAIL rstmid_restart t=%0d: got w=%08h idx=%0d expected w=%08h", t, w, w_idx, ref_w[t]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [511:0] a, b;
      logic [31:0]  ref_a [64];
      int gap;
      a = patt(32'd4);
      b = patt(32'd5);
      gen_sched(a);
      ref_a = ref_w;
      gen_sched(b);
      w_ready = 1'b1;
      @(negedge clk);
      blk = a;
      block_valid = 1'b1;
      vec_cnt++; if (block_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_idle_ready: got %b expected 1", block_ready); end
      @(negedge clk);
      blk = b;
      for (int t = 0; t < 64; t++) begin
         if (t > 0) @(negedge clk);
         vec_cnt++;
         if (w_valid !== 1'b1 || w !== ref_a[t] || w_idx !== 6'(t) || block_ready !== (B2B && t == 63)) begin
            err_cnt++;
            $display("FAIL b2b_a t=%0d: got w=%08h idx=%0d ready=%b expected w=%08h ready=%b",
                     t, w, w_idx, block_ready, ref_a[t], (B2B && t == 63));
         end
      end
      gap = 0;
      @(negedge clk);
      while (!w_valid && gap < 4) begin
         gap++;
         @(negedge clk);
      end
      block_valid = 1'b0;
      vec_cnt++; if (gap != (B2B ? 0 : 1)) begin err_cnt++; $display("FAIL b2b_gap: got %0d idle cycles expected %0d", gap, (B2B ? 0 : 1)); end
      vec_cnt++; if (w_valid !== 1'b1 || w !== ref_w[0] || w_idx !== 6'd0) begin
         err_cnt++; $display("FAIL b2b_b_first: got valid=%b w=%08h idx=%0d expected w=%08h idx=0", w_valid, w, w_idx, ref_w[0]);
      end
      for (int t = 1; t < 64; t++) begin
         @(negedge clk);
         vec_cnt++;
         if (w_valid !== 1'b1 || w !== ref_w[t] || w_idx !== 6'(t) || w_last !== (t == 63)) begin
            err_cnt++;
            $display("FAIL b2b_b t=%0d: got w=%08h idx=%0d last=%b expected w=%08h", t, w, w_idx, w_last, ref_w[t]);
         end
      end
      @(negedge clk);
      vec_cnt++; if (w_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_end_valid: got %b expected 0", w_valid); end
   endtask

   task automatic test_rounds16();
      w_ready16 = 1'b1;
      @(negedge clk);
      blk16 = patt(32'd6);
      block_valid16 = 1'b1;
      vec_cnt++; if (block_ready16 !== 1'b1) begin err_cnt++; $display("FAIL r16_ready: got %b expected 1", block_ready16); end
      @(negedge clk);
      block_valid16 = 1'b0;
      for (int t = 0; t < 16; t++) begin
         if (t > 0) @(negedge clk);
         vec_cnt++;
         if (w_valid16 !== 1'b1 || w16 !== blk16[511 - 32*t -: 32] || w_idx16 !== 6'(t) || w_last16 !== (t == 15)) begin
            err_cnt++;
            $display("FAIL r16_word t=%0d: got valid=%b w=%08h idx=%0d last=%b expected w=%08h last=%b",
                     t, w_valid16, w16, w_idx16, w_last16, blk16[511 - 32*t -: 32], (t == 15));
         end
      end
      @(negedge clk);
      vec_cnt++; if (w_valid16 !== 1'b0) begin err_cnt++; $display("FAIL r16_end_valid: got %b expected 0", w_valid16); end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_sigma0();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_rounds16();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
